// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback stage.
//   XLEN     : register / write-port data width
//   REG_X0   : hard-wired zero register index
//   wb_req_t : one register-write request (valid, rd, data)
package writeback_arbiter_pkg;

  localparam int         XLEN   = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// Ordered buffer of ALU writes waiting for the register-file write port.
// Ports:
//   clk, reset          : clock, async active-high reset
//   push/push_rd/_data  : append a new (youngest) entry at the tail
//   pop                 : retire the head entry (the caller writes head)
//   squash/squash_rd    : drop every queued entry whose rd matches
//   head                : oldest entry; head.valid == buffer non-empty
//   count               : number of live entries
//   rs*_addr/_hit/_data : newest-match lookup for both read ports
//
// Entries are kept packed toward slot 0 in program order. Squashed and
// popped entries are removed at the same edge and the survivors slide
// down, so a squash never leaves a hole that costs a slot or a drain
// cycle, and count is always the live-entry count.
module wb_pending_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [4:0]      push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            squash,
  input  logic [4:0]      squash_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output wb_req_t         head,
  output logic [CW-1:0]   count,
  output logic            rs1_hit,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs2_hit,
  output logic [XLEN-1:0] rs2_data
);

  wb_req_t [DEPTH-1:0] ent_q, ent_d;
  logic    [CW-1:0]    cnt_q, cnt_d;

  // Drop popped/squashed entries, compact survivors, then append the push.
  // The push lands after the squash, so a same-cycle ALU write (younger
  // than the load) is never squashed.
  always_comb begin
    ent_d = '0;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && !(pop && i == 0) &&
          !(squash && ent_q[i].rd == squash_rd)) begin
        ent_d[cnt_d[AW-1:0]] = ent_q[i];
        cnt_d = cnt_d + CW'(1);
      end
    end
    if (push && cnt_d < CW'(DEPTH)) begin
      ent_d[cnt_d[AW-1:0]] = '{valid: 1'b1, rd: push_rd, data: push_data};
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = ent_q[0];
  assign count = cnt_q;

  // Higher slots are younger; the last match in the scan wins.
  always_comb begin
    rs1_hit  = 1'b0;
    rs1_data = '0;
    rs2_hit  = 1'b0;
    rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].rd == rs1_addr) begin
        rs1_hit  = 1'b1;
        rs1_data = ent_q[i].data;
      end
      if (ent_q[i].valid && ent_q[i].rd == rs2_addr) begin
        rs2_hit  = 1'b1;
        rs2_data = ent_q[i].data;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage + 32 x XLEN integer register file.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   alu_write_req/_addr/_data   : execute-stage result
//   mem_write_req/_addr/_data   : load return from data_memory_ctrl
//   rs1_addr/rs2_addr           : read addresses
//   rs1_value/rs2_value         : combinational read data (youngest value)
//   alu_stall                   : pending buffer full, ALU request refused
//   pending_count               : live entries in the pending buffer
//
// Single write port, priority: load > pending head > direct ALU write.
// ALU writes that cannot take the port queue behind older ALU writes.
module writeback_arbiter
  import writeback_arbiter_pkg::wb_req_t, writeback_arbiter_pkg::REG_X0;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_write_req,
  input  logic [4:0]      alu_write_addr,
  input  logic [XLEN-1:0] alu_write_data,
  input  logic            mem_write_req,
  input  logic [4:0]      mem_write_addr,
  input  logic [XLEN-1:0] mem_write_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] rs2_value,
  output logic            alu_stall,
  output logic [CW-1:0]   pending_count
);

  logic [31:0][XLEN-1:0] regs;

  wb_req_t         head;
  logic [CW-1:0]   fifo_cnt;
  logic            rs1_hit, rs2_hit;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  logic            alu_v, mem_v, fifo_pop, alu_direct, alu_push;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  // Stall depends only on registered count, never on this cycle's request.
  assign alu_stall     = (fifo_cnt == CW'(DEPTH));
  assign pending_count = fifo_cnt;

  // x0 requests vanish here: no port use, no enqueue, no squash.
  assign alu_v      = alu_write_req && (alu_write_addr != REG_X0) && !alu_stall;
  assign mem_v      = mem_write_req && (mem_write_addr != REG_X0);
  assign fifo_pop   = !mem_v && head.valid;
  // Direct write only when nothing older is queued, keeping program order.
  assign alu_direct = alu_v && !mem_v && !head.valid;
  assign alu_push   = alu_v && !alu_direct;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = REG_X0;
    wr_data = '0;
    if (mem_v) begin
      wr_en   = 1'b1;
      wr_addr = mem_write_addr;
      wr_data = mem_write_data;
    end else if (fifo_pop) begin
      wr_en   = 1'b1;
      wr_addr = head.rd;
      wr_data = head.data;
    end else if (alu_direct) begin
      wr_en   = 1'b1;
      wr_addr = alu_write_addr;
      wr_data = alu_write_data;
    end
  end

  wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (alu_push),
    .push_rd   (alu_write_addr),
    .push_data (alu_write_data),
    .pop       (fifo_pop),
    .squash    (mem_v),
    .squash_rd (mem_write_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .head      (head),
    .count     (fifo_cnt),
    .rs1_hit   (rs1_hit),
    .rs1_data  (rs1_fwd),
    .rs2_hit   (rs2_hit),
    .rs2_data  (rs2_fwd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      regs <= '0;
    else if (wr_en) regs[wr_addr] <= wr_data;
  end

  assign rs1_value = (rs1_addr == REG_X0) ? '0 : rs1_hit ? rs1_fwd : regs[rs1_addr];
  assign rs2_value = (rs2_addr == REG_X0) ? '0 : rs2_hit ? rs2_fwd : regs[rs2_addr];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter. Each step drives one cycle of
// inputs just after the rising edge and queues the outputs expected during
// that cycle; the monitor pops and compares on the falling edge.
module tb_writeback_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_write_req, mem_write_req;
  logic [4:0]      alu_write_addr, mem_write_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] alu_write_data, mem_write_data;
  logic [XLEN-1:0] rs1_value, rs2_value;
  logic            alu_stall;
  logic [CW-1:0]   pending_count;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_write_req  (alu_write_req),
    .alu_write_addr (alu_write_addr),
    .alu_write_data (alu_write_data),
    .mem_write_req  (mem_write_req),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_value      (rs1_value),
    .rs2_value      (rs2_value),
    .alu_stall      (alu_stall),
    .pending_count  (pending_count)
  );

  typedef struct {
    int          id;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ec;
    logic [31:0] es;
  } exp_t;

  exp_t sbq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued record.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        m = sbq.pop_front();
        chk("rs1_value",     m.id, rs1_value,              m.e1);
        chk("rs2_value",     m.id, rs2_value,              m.e2);
        chk("pending_count", m.id, 32'(pending_count),     m.ec);
        chk("alu_stall",     m.id, {31'd0, alu_stall},     m.es);
      end
    end
  end

  task automatic step(input logic rs,
                      input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mr, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input int ec, input logic es);
    exp_t x;
    reset          = rs;
    alu_write_req  = ar;
    alu_write_addr = aa;
    alu_write_data = ad;
    mem_write_req  = mr;
    mem_write_addr = ma;
    mem_write_data = md;
    rs1_addr       = r1;
    rs2_addr       = r2;
    step_no++;
    x.id = step_no;
    x.e1 = e1;
    x.e2 = e2;
    x.ec = 32'(ec);
    x.es = {31'd0, es};
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_write_req = 1'b0; alu_write_addr = '0; alu_write_data = '0;
    mem_write_req = 1'b0; mem_write_addr = '0; mem_write_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    @(posedge clk);
    #1;
    //    rst  alu           load              rs1 rs2  exp1       exp2      cnt stall
    // reset state
    step(1, 0, 0, 0,       0, 0, 0,          5,  6,  0,         0,        0, 0);
    // direct ALU write, visible the next cycle
    step(0, 1, 5, 'h64,    0, 0, 0,          5,  0,  0,         0,        0, 0);
    step(0, 0, 0, 0,       0, 0, 0,          5,  0,  'h64,      0,        0, 0);
    // collision: load wins, ALU parked then drains
    step(0, 1, 6, 'h11,    1, 7, 'h22,       6,  7,  0,         0,        0, 0);
    step(0, 0, 0, 0,       0, 0, 0,          7,  6,  'h22,      'h11,     1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          6,  7,  'h11,      'h22,     0, 0);
    // full buffer: loads for 4 cycles, ALU x8..x11 held while stalled
    step(0, 1, 8, 'h808,   1, 20, 'h120,     8,  0,  0,         0,        0, 0);
    step(0, 1, 9, 'h909,   1, 21, 'h121,     8,  9,  'h808,     0,        1, 0);
    step(0, 1, 10, 'hA0A,  1, 22, 'h122,     10, 9,  0,         'h909,    2, 1);
    step(0, 1, 10, 'hA0A,  1, 23, 'h123,     20, 22, 'h120,     'h122,    2, 1);
    step(0, 1, 10, 'hA0A,  0, 0, 0,          23, 8,  'h123,     'h808,    2, 1);
    step(0, 1, 10, 'hA0A,  0, 0, 0,          8,  9,  'h808,     'h909,    1, 0);
    step(0, 1, 11, 'hB0B,  0, 0, 0,          10, 11, 'hA0A,     0,        1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          11, 9,  'hB0B,     'h909,    1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          10, 11, 'hA0A,     'hB0B,    0, 0);
    // WAW squash by a younger load
    step(0, 1, 9, 'hAAAA,  1, 3, 'h3333,     9,  3,  'h909,     0,        0, 0);
    step(0, 0, 0, 0,       1, 9, 'hBBBB,     9,  3,  'hAAAA,    'h3333,   1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          9,  3,  'hBBBB,    'h3333,   0, 0);
    step(0, 0, 0, 0,       0, 0, 0,          9,  8,  'hBBBB,    'h808,    0, 0);
    // x0 targets are discarded
    step(0, 1, 0, 'hFFFFFFFF, 1, 0, 'hFFFFFFFF, 0, 0, 0,        0,        0, 0);
    step(0, 0, 0, 0,       0, 0, 0,          0,  5,  0,         'h64,     0, 0);
    // two queued writes to x12: youngest is read, last one lands
    step(0, 1, 12, 'h1,    1, 13, 'hD,       12, 0,  0,         0,        0, 0);
    step(0, 1, 12, 'h2,    1, 14, 'hE,       12, 13, 'h1,       'hD,      1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          12, 13, 'h2,       'hD,      2, 1);
    step(0, 0, 0, 0,       0, 0, 0,          12, 14, 'h2,       'hE,      1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          12, 0,  'h2,       0,        0, 0);
    // squash of the tail entry frees its slot for an immediate push
    step(0, 1, 15, 'h15,   1, 18, 'h18,      15, 0,  0,         0,        0, 0);
    step(0, 1, 16, 'h16,   1, 19, 'h19,      15, 18, 'h15,      'h18,     1, 0);
    step(0, 0, 0, 0,       1, 16, 'h1616,    16, 19, 'h16,      'h19,     2, 1);
    step(0, 1, 17, 'h17,   1, 18, 'h1818,    16, 15, 'h1616,    'h15,     1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          17, 18, 'h17,      'h1818,   2, 1);
    step(0, 0, 0, 0,       0, 0, 0,          15, 17, 'h15,      'h17,     1, 0);
    step(0, 0, 0, 0,       0, 0, 0,          17, 16, 'h17,      'h1616,   0, 0);
    // mid-run async reset clears registers and the pending buffer at once
    step(0, 1, 22, 'h2222, 1, 21, 'h2121,    9,  0,  'hBBBB,    0,        0, 0);
    step(1, 0, 0, 0,       0, 0, 0,          9,  22, 0,         0,        0, 0);
    step(0, 0, 0, 0,       0, 0, 0,          22, 21, 0,         0,        0, 0);
    step(0, 1, 5, 'h77,    0, 0, 0,          5,  12, 0,         0,        0, 0);
    step(0, 0, 0, 0,       0, 0, 0,          5,  0,  'h77,      0,        0, 0);

    @(negedge clk);
    #1;
    chk("sb_drain", step_no, 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
